// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller for a byte-addressed, little-endian, combinational-read data memory.
//   Request side : req_valid_i/req_ready_i handshake, req_we_i, req_size_i (00 b, 01 h, 10 w, 11 rsvd),
//                  req_unsigned_i, req_addr_i, req_wdata_i (right-aligned store data)
//   Response side: resp_valid_o/resp_ready_i handshake, resp_rdata_o (extended load data, 0 for stores),
//                  resp_err_o (misaligned/reserved access, only with LSU_MISALIGN_TRAP_EN)
//   Memory side  : mem_addr_o, mem_we_o, mem_wdata_o, mem_rdata_i
//   Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned half/word and size 11 are answered with
//   resp_err_o=1 without touching memory. Undefined: resp_err_o is 0, size 11 acts as word.
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  typedef enum logic [2:0] {IDLE, LD, RMW_RD, WR, RESP} state_t;
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  // Holds the store data from acceptance; replaced by the merged word during RMW_RD.
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] ld_d;
  logic [DATA_WIDTH-1:0] merge_d;
  logic                  trap_d;
  always_comb begin
    ld_d    = size_q[1] ? mem_rdata_i
            : size_q[0] ? {{16{~uns_q & mem_rdata_i[15]}}, mem_rdata_i[15:0]}
            :             {{24{~uns_q & mem_rdata_i[7]}}, mem_rdata_i[7:0]};
    merge_d = size_q[0] ? {mem_rdata_i[31:16], mem_wdata_q[15:0]}
            :             {mem_rdata_i[31:8], mem_wdata_q[7:0]};
`ifdef LSU_MISALIGN_TRAP_EN
    trap_d  = (req_size_i == 2'b01 & req_addr_i[0]) | (req_size_i == 2'b10 & |req_addr_i[1:0]) | &req_size_i;
`else
    trap_d  = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          addr_q      <= req_addr_i;
          size_q      <= req_size_i;
          uns_q       <= req_unsigned_i;
          err_q       <= trap_d;
          rdata_q     <= '0;
          mem_wdata_q <= req_wdata_i;
          state_q     <= trap_d ? RESP : !req_we_i ? LD : req_size_i[1] ? WR : RMW_RD;
        end
        LD: begin
          rdata_q <= ld_d;
          state_q <= RESP;
        end
        RMW_RD: begin
          mem_wdata_q <= merge_d;
          state_q     <= WR;
        end
        WR:      state_q <= RESP;
        RESP:    if (resp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready_o  = state_q == IDLE;
  assign resp_valid_o = state_q == RESP;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_addr_o   = addr_q;
  assign mem_we_o     = state_q == WR;
  assign mem_wdata_o  = mem_wdata_q;
endmodule
